// File: rtl/eth_arp_tx_gmii.sv
// Sends one Ethernet II ARP frame (request or reply) on GMII per accepted
// start pulse: 7x 0x55 preamble, SFD, 42-byte header, zero pad, CRC32 FCS,
// then an inter-frame gap before accepting the next start.
// Ports:
//   clk_125m, rst_n        clock, synchronous active-low reset
//   tx_en_pulse            one-cycle start, honoured only while idle
//   arp_op                 0 = request, 1 = reply
//   src_mac/src_ip         local addresses
//   dst_mac/dst_ip         peer addresses (dst_mac used for reply only)
//   busy                   high from accepted start until end of IFG
//   tx_done                one-cycle pulse once the last FCS byte is sent
//   gmii_tx_clk/txen/txd   GMII transmit interface
module eth_arp_tx_gmii #(
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        tx_en_pulse,
  input  logic        arp_op,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  output logic        busy,
  output logic        tx_done,
  output logic        gmii_tx_clk,
  output logic        gmii_txen,
  output logic [7:0]  gmii_txd
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned IFG_W = $clog2(IFG_CYCLES + 1);
  localparam int unsigned HDR_W = 336;  // frame bytes 8..49

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_IFG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic [31:0]      crc;
  logic [HDR_W-1:0] hdr_sr;
  logic [HDR_W-1:0] hdr_c;
  logic [7:0]       byte_c;
  logic [31:0]      crc_c;

  assign gmii_tx_clk = clk_125m;

  // One byte of the reflected IEEE 802.3 CRC32, data LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Header image loaded at start; holding it in a shift register also freezes the inputs
  always_comb begin
    hdr_c = {arp_op ? dst_mac : 48'hFFFF_FFFF_FFFF,
             src_mac,
             16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
             arp_op ? 16'h0002 : 16'h0001,
             src_mac, src_ip,
             arp_op ? dst_mac : 48'h0,
             dst_ip};
  end

  // Byte selected by the position counter
  always_comb begin
    byte_c = 8'h00;
    if (cnt < 7'd7)       byte_c = 8'h55;
    else if (cnt == 7'd7) byte_c = 8'hD5;
    else if (cnt < 7'd50) byte_c = hdr_sr[HDR_W-1 -: 8];
    else if (cnt < 7'd68) byte_c = 8'h00;
    else                  byte_c = ~crc[7:0];
  end

  assign crc_c = crc_byte(crc, byte_c);

  // Frame sequencer with registered GMII outputs
  always_ff @(posedge clk_125m) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ifg_cnt   <= '0;
      crc       <= 32'hFFFF_FFFF;
      hdr_sr    <= '0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      gmii_txen <= 1'b0;
      gmii_txd  <= 8'h00;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          gmii_txen <= 1'b0;
          gmii_txd  <= 8'h00;
          if (tx_en_pulse) begin
            state  <= ST_SEND;
            busy   <= 1'b1;
            cnt    <= '0;
            crc    <= 32'hFFFF_FFFF;
            hdr_sr <= hdr_c;
          end
        end
        ST_SEND: begin
          if (cnt < 7'd72) begin
            gmii_txen <= 1'b1;
            gmii_txd  <= byte_c;
            cnt       <= cnt + 7'd1;
            if (cnt >= 7'd8 && cnt < 7'd50) hdr_sr <= {hdr_sr[HDR_W-9:0], 8'h00};
            // CRC covers bytes 8..67; during the FCS the register shifts out its next byte
            if (cnt >= 7'd8 && cnt < 7'd68) crc <= crc_c;
            else if (cnt >= 7'd68)          crc <= {8'h00, crc[31:8]};
          end else begin
            gmii_txen <= 1'b0;
            gmii_txd  <= 8'h00;
            tx_done   <= 1'b1;
            ifg_cnt   <= '0;
            state     <= ST_IFG;
          end
        end
        ST_IFG: begin
          // busy drops one edge early so a start can be taken IFG_CYCLES edges after tx_done
          if (ifg_cnt == IFG_W'(IFG_CYCLES - 2)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
